// File: rtl/spi_reg_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_pkg
// Shared constants and types for the SPI register controller:
//   - register address map of the PWM configuration registers
//   - frame length and bit-counter overflow marker
//   - controller FSM state type
// ---------------------------------------------------------------------------
package spi_reg_pkg;

   localparam int ADDR_EN_OUT_LO = 0;
   localparam int ADDR_EN_OUT_HI = 1;
   localparam int ADDR_EN_PWM_LO = 2;
   localparam int ADDR_EN_PWM_HI = 3;
   localparam int ADDR_DUTY      = 4;

   localparam int FRAME_BITS = 16;

   // Bit counter parks here once a frame runs past FRAME_BITS, so any
   // over-long frame stays distinguishable from a correct one.
   localparam logic [4:0] CNT_OVF = 5'd17;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/spi_reg_ctrl_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Brings one asynchronous pad input into the clk domain through SYNC_STAGES
// metastability flops, then one history flop for edge detection.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input
//   level      : synchronized level (last synchronizer flop)
//   rise, fall : single-cycle edge pulses from the last two flops
// RST_VAL sets the idle level all flops take in reset.
// ---------------------------------------------------------------------------
module sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   hist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {SYNC_STAGES{RST_VAL}};
         hist  <= RST_VAL;
      end else begin
         // Shift form keeps this legal for SYNC_STAGES == 1 as well.
         chain <= (chain << 1) | SYNC_STAGES'(din);
         hist  <= chain[SYNC_STAGES-1];
      end
   end

   assign level = chain[SYNC_STAGES-1];
   assign rise  = level & ~hist;
   assign fall  = ~level & hist;

endmodule

// File: rtl/spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl
// SPI mode-0 write-only slave that loads the PWM peripheral's configuration
// registers. Frames are 16 bits MSB first: {rw, addr[6:0], data[7:0]}.
// Ports:
//   clk, rst_n        : system clock, asynchronous active-low reset
//   sclk, ncs, copi   : asynchronous SPI pad inputs
//   en_reg_out_7_0    : register 0x00
//   en_reg_out_15_8   : register 0x01
//   en_reg_pwm_7_0    : register 0x02
//   en_reg_pwm_15_8   : register 0x03
//   pwm_duty_cycle    : register 0x04
//   wr_pulse          : one-cycle pulse when a register write commits
//   frame_err         : one-cycle pulse when a frame ends with != 16 bits
// ---------------------------------------------------------------------------
module spi_reg_ctrl
   import spi_reg_pkg::*;
#(
   parameter int NUM_REGS    = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       ncs,
   input  logic       copi,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_pulse,
   output logic       frame_err
);

   localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);

   logic sclk_level, sclk_rise, sclk_fall;
   logic ncs_level, ncs_rise, ncs_fall;
   logic copi_level, copi_rise, copi_fall;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .din(sclk),
      .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
   );

   // ncs idles high, so its chain resets high; a pin held low across reset
   // release therefore shows up as a frame start.
   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst_n(rst_n), .din(ncs),
      .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst_n(rst_n), .din(copi),
      .level(copi_level), .rise(copi_rise), .fall(copi_fall)
   );

   // Only level/edge subsets of each synchronizer are consumed.
   logic unused_sync;
   assign unused_sync = &{1'b0, sclk_level, sclk_fall, ncs_level,
                          copi_rise, copi_fall};

   state_t      state;
   logic [15:0] shreg;
   logic [4:0]  cnt;
   logic [7:0]  regs [NUM_REGS];

   logic       frame_ok;
   logic       is_write;
   logic [6:0] addr;
   logic [7:0] data;

   assign frame_ok = (cnt == 5'(FRAME_BITS));
   assign is_write = shreg[15];
   assign addr     = shreg[14:8];
   assign data     = shreg[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         shreg     <= '0;
         cnt       <= '0;
         wr_pulse  <= 1'b0;
         frame_err <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         wr_pulse  <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ncs_fall) begin
                  shreg <= '0;
                  cnt   <= '0;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Frame end takes priority: an sclk rise seen in the same
               // cycle as the ncs rise is not part of the frame.
               if (ncs_rise) begin
                  state <= ST_COMMIT;
               end else if (sclk_rise) begin
                  shreg <= {shreg[14:0], copi_level};
                  if (cnt != CNT_OVF) cnt <= cnt + 5'd1;
               end
            end
            ST_COMMIT: begin
               state <= ST_IDLE;
               if (!frame_ok) begin
                  frame_err <= 1'b1;
               end else if (is_write && (addr < NUM_REGS_A)) begin
                  wr_pulse <= 1'b1;
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (addr == 7'(i)) regs[i] <= data;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign en_reg_out_7_0  = regs[ADDR_EN_OUT_LO];
   assign en_reg_out_15_8 = regs[ADDR_EN_OUT_HI];
   assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_LO];
   assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI];
   assign pwm_duty_cycle  = regs[ADDR_DUTY];

endmodule
